// File: rtl/univ_shift_reg_pkg.sv
// Shared op-code definitions for the universal shift register.
package univ_shift_reg_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SHL   = 3'd1;
  localparam logic [OP_W-1:0] OP_SHR   = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL   = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR   = 3'd4;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd5;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd6;
  localparam logic [OP_W-1:0] OP_INV   = 3'd7;
endpackage

// File: rtl/univ_shift_reg_dff_r_en.sv
// Single-bit flop with synchronous active-low reset to RST_VAL and clock enable.
// Both q and q_bar come straight from flops.
module dff_r_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic q_bar
);

  logic q_r;
  logic q_bar_r;

  // State bit and its complement, reset taking priority over enable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r     <= RST_VAL;
      q_bar_r <= ~RST_VAL;
    end else if (en) begin
      q_r     <= d;
      q_bar_r <= ~d;
    end else begin
      q_r     <= q_r;
      q_bar_r <= q_bar_r;
    end
  end

  assign q     = q_r;
  assign q_bar = q_bar_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift, rotate, load, clear or invert per edge.
// Next-state mux feeds a row of enabled flops; every output comes from that row.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_bar,
  output logic              sout_l,
  output logic              sout_r,
  output logic              zero
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_bar_s;
  logic [WIDTH-1:0] next_s;

  // Next register value selected by the op code
  always_comb begin
    next_s = q_s;
    case (op)
      OP_HOLD:  next_s = q_s;
      OP_SHL:   next_s = {q_s[WIDTH-2:0], sin_l};
      OP_SHR:   next_s = {sin_r, q_s[WIDTH-1:1]};
      OP_ROL:   next_s = {q_s[WIDTH-2:0], q_s[WIDTH-1]};
      OP_ROR:   next_s = {q_s[0], q_s[WIDTH-1:1]};
      OP_LOAD:  next_s = d;
      OP_CLEAR: next_s = RESET_VAL;
      OP_INV:   next_s = ~q_s;
      default:  next_s = q_s;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_r_en #(
      .RST_VAL (RESET_VAL[i])
    ) u_dff (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .d       (next_s[i]),
      .q       (q_s[i]),
      .q_bar   (q_bar_s[i])
    );
  end

  assign q      = q_s;
  assign q_bar  = q_bar_s;
  assign sout_l = q_s[WIDTH-1];
  assign sout_r = q_s[0];
  assign zero   = ~|q_s;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes hand-computed expected q
// per edge, a monitor pops and checks every output just after each rising edge.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  d = 8'h00;
  logic        sin_l = 1'b0;
  logic        sin_r = 1'b0;
  logic [7:0]  q;
  logic [7:0]  q_bar;
  logic        sout_l;
  logic        sout_r;
  logic        zero;

  typedef struct {
    logic [7:0] q;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .op      (op),
    .d       (d),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .q       (q),
    .q_bar   (q_bar),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  // One edge of stimulus; expected q after that edge is queued at the edge
  task automatic step(input logic rst_n_v, input logic en_v, input logic [2:0] op_v,
                      input logic [7:0] d_v, input logic sl_v, input logic sr_v,
                      input logic [7:0] exp_q, input string name);
    exp_t e;
    @(negedge clk);
    reset_n = rst_n_v;
    en      = en_v;
    op      = op_v;
    d       = d_v;
    sin_l   = sl_v;
    sin_r   = sr_v;
    @(posedge clk);
    e.q    = exp_q;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: after every rising edge compare all outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".q"},      q,               e.q);
        check({e.name, ".q_bar"},  q_bar,           ~e.q);
        check({e.name, ".sout_l"}, {7'd0, sout_l},  {7'd0, e.q[7]});
        check({e.name, ".sout_r"}, {7'd0, sout_r},  {7'd0, e.q[0]});
        check({e.name, ".zero"},   {7'd0, zero},    {7'd0, (e.q == 8'h00)});
      end
    end
  end

  logic [7:0] rol_seq [9] = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
  logic [7:0] ror_seq [9] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5};
  logic [7:0] shl_seq [8] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  // Directed stimulus
  initial begin
    // reset dominates a pending LOAD of all ones
    step(1'b0, 1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00, "reset0");
    step(1'b0, 1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00, "reset1");

    step(1'b1, 1'b1, OP_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, "load_a5");
    for (int i = 1; i < 9; i++)
      step(1'b1, 1'b1, OP_ROL, 8'h00, 1'b1, 1'b1, rol_seq[i], $sformatf("rol%0d", i));
    for (int i = 1; i < 9; i++)
      step(1'b1, 1'b1, OP_ROR, 8'h00, 1'b1, 1'b1, ror_seq[i], $sformatf("ror%0d", i));

    step(1'b1, 1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, "load_81");
    step(1'b1, 1'b1, OP_SHL,  8'h00, 1'b1, 1'b0, 8'h03, "shl_sin1");
    step(1'b1, 1'b1, OP_SHR,  8'h00, 1'b0, 1'b1, 8'h81, "shr_sin1");

    step(1'b1, 1'b1, OP_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, "load_3c");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, OP_INV, 8'hFF, 1'b1, 1'b1, 8'h3C, $sformatf("en0_hold%0d", i));
    step(1'b1, 1'b1, OP_INV,  8'h00, 1'b0, 1'b0, 8'hC3, "inv");

    step(1'b1, 1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, "load_ff");
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, OP_SHL, 8'hFF, 1'b0, 1'b1, shl_seq[i], $sformatf("shl_empty%0d", i));

    step(1'b1, 1'b1, OP_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A, "load_5a");
    step(1'b1, 1'b1, OP_HOLD, 8'hFF, 1'b1, 1'b1, 8'h5A, "op_hold");
    step(1'b1, 1'b1, OP_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00, "clear");

    step(1'b1, 1'b1, OP_LOAD, 8'h55, 1'b0, 1'b0, 8'h55, "load_55");
    step(1'b1, 1'b1, OP_SHL,  8'h00, 1'b0, 1'b0, 8'hAA, "mid_shl");
    step(1'b0, 1'b1, OP_SHL,  8'h00, 1'b1, 1'b0, 8'h00, "mid_reset");
    step(1'b1, 1'b1, OP_SHL,  8'h00, 1'b1, 1'b0, 8'h01, "post_reset_shl");

    @(negedge clk);
    en = 1'b0;
    stim_done = 1'b1;
  end

  // Bounded drain of the scoreboard, then summary
  initial begin
    int budget;
    budget = 2000;
    while (!(stim_done && sb.size() == 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() != 0 || !stim_done) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, stim_done=%0d, required 0 entries and stim_done=1",
               sb.size(), stim_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
